// File: rtl/misc_op_stash_pkg.sv
// Shared types for the misc-opcode path: opcode encoding, width and a legality helper.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
package misc_op_stash_pkg;

   localparam int MISC_OP_W = 3;

   // A is a single code; B and C each cover two codes (low bit is don't-care).
   typedef enum logic [MISC_OP_W-1:0] {
      MISC_OP_A = 3'b000,
      MISC_OP_B = 3'b100,
      MISC_OP_C = 3'b110
   } misc_opcode_e;

   // Same wildcard patterns the decoder's casez uses: 000, 10?, 11?.
   function automatic logic misc_op_legal(input logic [MISC_OP_W-1:0] op);
      logic ok;
      casez (op)
         3'b000:  ok = 1'b1;
         3'b10?:  ok = 1'b1;
         3'b11?:  ok = 1'b1;
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/misc_stash_ring.sv
// Ring buffer for buffered opcodes: storage array, read/write pointers and occupancy count.
// Latency: a write at edge N is readable at rd_dat after edge N; rd_dat is the head entry.
// Backpressure: none internally; caller must not write when full nor read when empty.
module misc_stash_ring #(
   parameter int DEPTH = 4,
   parameter int W     = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     wr_en,
   input  logic [W-1:0]             wr_dat,
   input  logic                     rd_en,
   output logic [W-1:0]             rd_dat,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   // Pointers wrap naturally since DEPTH is a power of two; count is one bit wider to hold DEPTH.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + 1'b1;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(wr_en) - CW'(rd_en);
      end
   end

   // Storage is cleared on reset so the head never presents X, even before the first write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (wr_en && !flush) begin
         mem[wr_ptr] <= wr_dat;
      end
   end

   assign rd_dat = mem[rd_ptr];

endmodule

// File: rtl/misc_op_stash.sv
// Opcode stash ahead of the misc decoder; optional illegal-opcode filter via MISC_STASH_ILLEGAL_CHK_EN.
// Latency: push at edge N is visible on out_valid/stash after edge N (no same-cycle bypass).
// Backpressure: in_ready drops when full (no pop-through) or during flush; stalls are counted.
module misc_op_stash
   import misc_op_stash_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int STALL_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [MISC_OP_W-1:0]     in_op,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [MISC_OP_W-1:0]     stash,
   output logic [$clog2(DEPTH):0]   count,
   output logic [STALL_W-1:0]       stall_cnt,
   output logic                     illegal
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [STALL_W-1:0] STALL_MAX = '1;

   typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} stash_state_e;

   stash_state_e           state_q, state_d;
   logic                   rdy_q;
   logic                   push_hs;
   logic                   pop;
   logic                   op_ok;
   logic                   wr_en;
   logic [MISC_OP_W-1:0]   head;

   assign in_ready  = rdy_q && (count < CW'(DEPTH)) && !flush;
   assign push_hs   = in_valid && in_ready;
   assign out_valid = (state_q != EMPTY);
   // A pop coinciding with flush is not treated as consumed.
   assign pop       = out_valid && out_ready && !flush;
   assign wr_en     = push_hs && op_ok;
   assign stash     = out_valid ? head : '0;

`ifdef MISC_STASH_ILLEGAL_CHK_EN
   assign op_ok = misc_op_legal(in_op);

   // Illegal opcodes still complete the handshake; flag them one cycle later.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) illegal <= 1'b0;
      else        illegal <= push_hs && !op_ok;
   end
`else
   assign op_ok   = 1'b1;
   assign illegal = 1'b0;
`endif

   misc_stash_ring #(
      .DEPTH (DEPTH),
      .W     (MISC_OP_W)
   ) u_ring (
      .clk    (clk),
      .rst_n  (rst_n),
      .flush  (flush),
      .wr_en  (wr_en),
      .wr_dat (in_op),
      .rd_en  (pop),
      .rd_dat (head),
      .count  (count)
   );

   // Hold in_ready low through reset and until the first edge after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rdy_q <= 1'b0;
      else        rdy_q <= 1'b1;
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= EMPTY;
      else        state_q <= state_d;
   end

   // Next state tracks occupancy: empty / some / full; flush always returns to EMPTY.
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY:   if (wr_en) state_d = PARTIAL;
            PARTIAL: begin
               if (wr_en && !pop && (count == CW'(DEPTH - 1)))
                  state_d = FULL;
               else if (pop && !wr_en && (count == CW'(1)))
                  state_d = EMPTY;
            end
            FULL:    if (pop) state_d = PARTIAL;
            default: state_d = EMPTY;
         endcase
      end
   end

   // Saturating count of cycles where the decoder holds off a valid stash.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         stall_cnt <= '0;
      else if (flush)
         stall_cnt <= '0;
      else if (out_valid && !out_ready && (stall_cnt != STALL_MAX))
         stall_cnt <= stall_cnt + 1'b1;
   end

endmodule

// File: tb/tb_misc_op_stash.sv
// Directed self-checking bench for misc_op_stash (default DEPTH=4, STALL_W=8).
// Latency: inputs driven and outputs sampled 1ns after each rising edge.
// Backpressure: exercised by holding out_ready low against a full stash.
module tb_misc_op_stash;

   logic       clk;
   logic       rst_n;
   logic       flush;
   logic       in_valid;
   logic       in_ready;
   logic [2:0] in_op;
   logic       out_valid;
   logic       out_ready;
   logic [2:0] stash;
   logic [2:0] count;
   logic [7:0] stall_cnt;
   logic       illegal;

   int n_chk  = 0;
   int n_fail = 0;

   misc_op_stash #(.DEPTH(4), .STALL_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_op     (in_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .stash     (stash),
      .count     (count),
      .stall_cnt (stall_cnt),
      .illegal   (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_op     = 3'b000;
      out_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check("rst_in_ready",  32'(in_ready),  32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_count",     32'(count),     32'd0);
      check("rst_stash",     32'(stash),     32'd0);
      check("rst_stall",     32'(stall_cnt), 32'd0);
      check("rst_illegal",   32'(illegal),   32'd0);
      step();
      rst_n = 1'b1;
      check("rel_in_ready_low", 32'(in_ready), 32'd0);
      step();
      check("rel_in_ready_high", 32'(in_ready), 32'd1);

      // 1: single push of 101, visible next cycle, then popped.
      in_valid = 1'b1; in_op = 3'b101;
      step();
      in_valid = 1'b0;
      check("t1_out_valid", 32'(out_valid), 32'd1);
      check("t1_stash",     32'(stash),     32'h5);
      check("t1_count",     32'(count),     32'd1);
      out_ready = 1'b1;
      step();
      check("t1_pop_count", 32'(count),     32'd0);
      check("t1_pop_valid", 32'(out_valid), 32'd0);
      check("t1_pop_stash", 32'(stash),     32'd0);
      check("t1_stall",     32'(stall_cnt), 32'd0);

      // 2: fill to DEPTH with the decoder stalled; a fifth push is held off.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_op = 3'b000; step();
      in_op = 3'b100; step();
      in_op = 3'b110; step();
      in_op = 3'b111; step();
      check("t2_count",    32'(count),     32'd4);
      check("t2_in_ready", 32'(in_ready),  32'd0);
      check("t2_stall",    32'(stall_cnt), 32'd3);
      in_op = 3'b011; step(); step();
      check("t2_held_count", 32'(count),     32'd4);
      check("t2_stall_more", 32'(stall_cnt), 32'd5);
      check("t2_head",       32'(stash),     32'd0);

      // 3: full with push and pop together -> pop only.
      in_op = 3'b101; out_ready = 1'b1;
      step();
      check("t3_count",  32'(count),     32'd3);
      check("t3_head1",  32'(stash),     32'h4);
      check("t3_stall",  32'(stall_cnt), 32'd5);
      in_valid = 1'b0;
      step();
      check("t3_count2", 32'(count), 32'd2);
      check("t3_head2",  32'(stash), 32'h6);

      // 4: flush beats a concurrent push and pop.
      flush = 1'b1; in_valid = 1'b1; in_op = 3'b000;
      #1;
      check("t4_in_ready_flush", 32'(in_ready), 32'd0);
      step();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      check("t4_count", 32'(count),     32'd0);
      check("t4_valid", 32'(out_valid), 32'd0);
      check("t4_stash", 32'(stash),     32'd0);
      check("t4_stall", 32'(stall_cnt), 32'd0);

      // 5: opcode 010 -- filtered when the legality check is built in.
      in_valid = 1'b1; in_op = 3'b010;
      #1;
      check("t5_in_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0; out_ready = 1'b1;
`ifdef MISC_STASH_ILLEGAL_CHK_EN
      check("t5_illegal", 32'(illegal),   32'd1);
      check("t5_count",   32'(count),     32'd0);
      check("t5_valid",   32'(out_valid), 32'd0);
      step();
      check("t5_illegal_pulse", 32'(illegal), 32'd0);
`else
      check("t5_illegal", 32'(illegal), 32'd0);
      check("t5_count",   32'(count),   32'd1);
      check("t5_stash",   32'(stash),   32'h2);
      step();
      check("t5_drain",   32'(count),   32'd0);
`endif

      // 6: saturate the stall counter at count=3, then reset mid-cycle.
      out_ready = 1'b0; in_valid = 1'b1;
      in_op = 3'b000; step();
      in_op = 3'b100; step();
      in_op = 3'b101; step();
      in_valid = 1'b0;
      repeat (260) step();
      check("t6_count",    32'(count),     32'd3);
      check("t6_stall_sat", 32'(stall_cnt), 32'd255);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_valid", 32'(out_valid), 32'd0);
      check("t6_rst_count", 32'(count),     32'd0);
      check("t6_rst_stash", 32'(stash),     32'd0);
      check("t6_rst_stall", 32'(stall_cnt), 32'd0);
      check("t6_rst_ready", 32'(in_ready),  32'd0);
      step();
      rst_n = 1'b1;
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
